// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
//
// Single-clock FIFO controller that turns a dual-port SRAM (write port A,
// registered read port B) into a valid/ready stream buffer. The SRAM holds up
// to 2^AWIDTH words. A 2-entry output buffer hides the SRAM's 1-cycle read
// latency, so the stream sustains one word per cycle. Total storage is
// 2^AWIDTH + 2 words.
//
// Handshakes: a word moves on a port only in a cycle where both valid and
// ready are high at the rising edge of CLK. WR_READY never depends on
// WR_VALID. RD_VALID/RD_DATA stay stable while RD_VALID=1 and RD_READY=0.
//
// Optional feature (macro SRAM_FIFO_STATUS_EN):
//   LEVEL    out [AWIDTH+1:0]  registered occupancy (SRAM + buffer + in-flight)
//   OVERFLOW out 1             sticky, set on WR_VALID while WR_READY=0
//   CLR_ERR  in  1             synchronous clear of OVERFLOW (set wins)
//
// Ports:
//   CLK, RST            clock (rising edge), async active-high reset
//   FLUSH               synchronous clear of all contents
//   WR_VALID/READY/DATA push stream
//   RD_VALID/READY/DATA pop stream, RD_DATA registered
//   SRAM_ENA/WEA/ADDRA/DINA   SRAM port A (write), combinational
//   SRAM_ENB/ADDRB            SRAM port B (read request), combinational
//   SRAM_DOUTB                SRAM port B registered read data
// -----------------------------------------------------------------------------
module sram_fifo_ctrl #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic [DWIDTH-1:0] WR_DATA,
    output logic              RD_VALID,
    input  logic              RD_READY,
    output logic [DWIDTH-1:0] RD_DATA,
    output logic              SRAM_ENA,
    output logic              SRAM_WEA,
    output logic [AWIDTH-1:0] SRAM_ADDRA,
    output logic [DWIDTH-1:0] SRAM_DINA,
    output logic              SRAM_ENB,
    output logic [AWIDTH-1:0] SRAM_ADDRB,
    input  logic [DWIDTH-1:0] SRAM_DOUTB
`ifdef SRAM_FIFO_STATUS_EN
    ,
    output logic [AWIDTH+1:0] LEVEL,
    output logic              OVERFLOW,
    input  logic              CLR_ERR
`endif
);

    localparam logic [AWIDTH:0] DEPTH   = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AWIDTH:0]   wptr_q, wptr_d;
    logic [AWIDTH:0]   rptr_q, rptr_d;
    logic [1:0]        out_cnt_q, out_cnt_d;
    logic              inflight_q, inflight_d;
    logic [DWIDTH-1:0] slot0_q, slot0_d;
    logic [DWIDTH-1:0] slot1_q, slot1_d;

    logic [AWIDTH:0]   mem_cnt;
    logic              mem_full;
    logic              mem_empty;
    logic              wr_ready;
    logic              push;
    logic              pop;
    logic              fetch;
    logic [2:0]        buf_need;

    // Occupancy uses registered pointers only, so a same-cycle push is never
    // visible to fetch and the two ports never touch the same location.
    assign mem_cnt   = wptr_q - rptr_q;
    assign mem_full  = (mem_cnt == DEPTH);
    assign mem_empty = (mem_cnt == '0);

    assign wr_ready  = !mem_full && !FLUSH && !RST;
    assign push      = WR_VALID && wr_ready;
    assign pop       = (out_cnt_q != 2'd0) && RD_READY;

    // Buffer slots that will be committed after this edge, counting the read
    // already in flight. Fetch only if a slot remains for the new read.
    assign buf_need  = {1'b0, out_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fetch     = !mem_empty && (buf_need < 3'd2) && !RST;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        out_cnt_d  = out_cnt_q;
        inflight_d = inflight_q;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        if (FLUSH) begin
            wptr_d     = '0;
            rptr_d     = '0;
            out_cnt_d  = 2'd0;
            inflight_d = 1'b0;
            slot0_d    = '0;
            slot1_d    = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (fetch) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            inflight_d = fetch;
            out_cnt_d  = out_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
            if (pop) begin
                slot0_d = slot1_q;
            end
            // Returning read lands in the first slot not holding a live word
            // after this cycle's pop.
            if (inflight_q) begin
                if ((out_cnt_q == 2'd0) || ((out_cnt_q == 2'd1) && pop)) begin
                    slot0_d = SRAM_DOUTB;
                end else begin
                    slot1_d = SRAM_DOUTB;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            out_cnt_q  <= 2'd0;
            inflight_q <= 1'b0;
            slot0_q    <= '0;
            slot1_q    <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= inflight_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
        end
    end

    assign WR_READY   = wr_ready;
    assign RD_VALID   = (out_cnt_q != 2'd0);
    assign RD_DATA    = slot0_q;
    assign SRAM_ENA   = push;
    assign SRAM_WEA   = push;
    assign SRAM_ADDRA = wptr_q[AWIDTH-1:0];
    assign SRAM_DINA  = RST ? '0 : WR_DATA;
    assign SRAM_ENB   = fetch;
    assign SRAM_ADDRB = rptr_q[AWIDTH-1:0];

`ifdef SRAM_FIFO_STATUS_EN
    logic [AWIDTH+1:0] level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [AWIDTH:0]   mem_cnt_d;

    // Level tracks the state being committed at this edge, so it agrees with
    // the pointers and buffer in the same cycle.
    assign mem_cnt_d = wptr_d - rptr_d;

    always_comb begin
        level_d    = {1'b0, mem_cnt_d}
                   + {{AWIDTH{1'b0}}, out_cnt_d}
                   + {{(AWIDTH + 1){1'b0}}, inflight_d};
        overflow_d = overflow_q;
        if (CLR_ERR) begin
            overflow_d = 1'b0;
        end
        if (WR_VALID && !wr_ready && !FLUSH) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    assign LEVEL    = level_q;
    assign OVERFLOW = overflow_q;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for sram_fifo_ctrl. Contains a behavioural dual-port SRAM, a
// table of per-cycle vectors for the basic latency/flush behaviour, hand
// sequences for fill, flush and reset, and a randomized stream checked
// against a queue reference model.
// -----------------------------------------------------------------------------
module tb_sram_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK;
  logic          RST;
  logic          FLUSH;
  logic          WR_VALID;
  logic          WR_READY;
  logic [DW-1:0] WR_DATA;
  logic          RD_VALID;
  logic          RD_READY;
  logic [DW-1:0] RD_DATA;
  logic          SRAM_ENA;
  logic          SRAM_WEA;
  logic [AW-1:0] SRAM_ADDRA;
  logic [DW-1:0] SRAM_DINA;
  logic          SRAM_ENB;
  logic [AW-1:0] SRAM_ADDRB;
  logic [DW-1:0] SRAM_DOUTB;
`ifdef SRAM_FIFO_STATUS_EN
  logic [AW+1:0] LEVEL;
  logic          OVERFLOW;
  logic          CLR_ERR;
`endif

  sram_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .FLUSH      (FLUSH),
    .WR_VALID   (WR_VALID),
    .WR_READY   (WR_READY),
    .WR_DATA    (WR_DATA),
    .RD_VALID   (RD_VALID),
    .RD_READY   (RD_READY),
    .RD_DATA    (RD_DATA),
    .SRAM_ENA   (SRAM_ENA),
    .SRAM_WEA   (SRAM_WEA),
    .SRAM_ADDRA (SRAM_ADDRA),
    .SRAM_DINA  (SRAM_DINA),
    .SRAM_ENB   (SRAM_ENB),
    .SRAM_ADDRB (SRAM_ADDRB),
    .SRAM_DOUTB (SRAM_DOUTB)
`ifdef SRAM_FIFO_STATUS_EN
    ,
    .LEVEL      (LEVEL),
    .OVERFLOW   (OVERFLOW),
    .CLR_ERR    (CLR_ERR)
`endif
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural SRAM: write port A, registered read port B.
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (SRAM_ENA && SRAM_WEA) sram_mem[SRAM_ADDRA] <= SRAM_DINA;
    if (SRAM_ENB) SRAM_DOUTB <= sram_mem[SRAM_ADDRB];
  end

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  int            n_vec;
  int            n_miss;
  int            n_push;
  int            n_pop;
  logic [DW-1:0] last_pop_data;
  logic          last_wr_ready;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  typedef struct {
    logic          wv;
    logic [DW-1:0] wd;
    logic          rr;
    logic          fl;
    logic          exp_wr;
    logic          exp_rv;
    logic          chk_d;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  // One clock cycle of stimulus with reference-model checking. Inputs are
  // applied just after an edge; outputs are sampled 1 time unit later.
  task automatic drive_cycle(input logic wv, input logic [DW-1:0] wd,
                             input logic rr, input logic fl);
    int            size0;
    logic [DW-1:0] want_d;
    WR_VALID = wv;
    WR_DATA  = wd;
    RD_READY = rr;
    FLUSH    = fl;
    #1;
    last_wr_ready = WR_READY;
    size0 = exp_q.size();
    if (prev_stall) begin
      chk("stall_valid", 64'(RD_VALID), 64'd1);
      chk("stall_data", 64'(RD_DATA), 64'(prev_data));
    end
    if (fl) begin
      chk("flush_wr_ready", 64'(WR_READY), 64'd0);
      exp_q.delete();
    end else begin
      if (size0 < 32) chk("wr_ready_room", 64'(WR_READY), 64'd1);
      if (RD_VALID) begin
        if (size0 == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL extra_beat: RD_VALID=1 data %0h, want no word", RD_DATA);
        end else if (rr) begin
          want_d = exp_q.pop_front();
          chk("rd_data", 64'(RD_DATA), 64'(want_d));
          n_pop++;
          last_pop_data = RD_DATA;
        end
      end
      if (wv && WR_READY) begin
        chk("capacity", 64'(size0 < 34), 64'd1);
        exp_q.push_back(wd);
        n_push++;
      end
    end
    prev_stall = RD_VALID && !rr && !fl;
    prev_data  = RD_DATA;
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    int p0;
    int q0;
    n_vec = 0; n_miss = 0; n_push = 0; n_pop = 0;
    prev_stall = 1'b0; prev_data = '0; last_pop_data = '0; last_wr_ready = 1'b0;
    FLUSH = 1'b0; RD_READY = 1'b0;
    WR_VALID = 1'b1; WR_DATA = 32'hFFFF_FFFF;
`ifdef SRAM_FIFO_STATUS_EN
    CLR_ERR = 1'b0;
`endif

    // Reset state, checked while RST is high with a push offered
    RST = 1'b1;
    #1;
    chk("rst_rd_valid", 64'(RD_VALID), 64'd0);
    chk("rst_rd_data", 64'(RD_DATA), 64'd0);
    chk("rst_wr_ready", 64'(WR_READY), 64'd0);
    chk("rst_sram_ena", 64'({SRAM_ENA, SRAM_WEA, SRAM_ENB}), 64'd0);
    chk("rst_sram_dina", 64'(SRAM_DINA), 64'd0);
    chk("rst_sram_addr", 64'({SRAM_ADDRA, SRAM_ADDRB}), 64'd0);
`ifdef SRAM_FIFO_STATUS_EN
    chk("rst_level", 64'(LEVEL), 64'd0);
    chk("rst_overflow", 64'(OVERFLOW), 64'd0);
`endif
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    WR_VALID = 1'b0;

    // Table: 3-word burst with 3-cycle first-word latency, then a FLUSH
    // cycle whose push must be dropped.
    //          wv    wd            rr    fl    wr    rv    chkd  data
    tbl[0]  = '{1'b1, 32'h1,        1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[1]  = '{1'b1, 32'h2,        1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[2]  = '{1'b1, 32'h3,        1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3};
    tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 32'h5555_5555, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      WR_VALID = tbl[i].wv;
      WR_DATA  = tbl[i].wd;
      RD_READY = tbl[i].rr;
      FLUSH    = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_wr_ready", i), 64'(WR_READY), 64'(tbl[i].exp_wr));
      chk($sformatf("tbl%0d_rd_valid", i), 64'(RD_VALID), 64'(tbl[i].exp_rv));
      if (tbl[i].chk_d) chk($sformatf("tbl%0d_rd_data", i), 64'(RD_DATA), 64'(tbl[i].exp_d));
      @(posedge CLK);
      #1;
    end

    // Fill with RD_READY=0 until WR_READY drops: 34 words accepted.
    p0 = n_push;
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
      if (!last_wr_ready) break;
    end
    chk("fill_accepted", 64'(n_push - p0), 64'd34);
    chk("fill_wr_ready_low", 64'(WR_READY), 64'd0);
`ifdef SRAM_FIFO_STATUS_EN
    chk("fill_overflow", 64'(OVERFLOW), 64'd1);
    chk("fill_level", 64'(LEVEL), 64'd34);
    WR_VALID = 1'b0;
    CLR_ERR  = 1'b1;
    @(posedge CLK);
    #1;
    CLR_ERR  = 1'b0;
    chk("clr_err_overflow", 64'(OVERFLOW), 64'd0);
`endif
    q0 = n_pop;
    drain(45);
    chk("fill_popped", 64'(n_pop - q0), 64'd34);
    chk("fill_model_empty", 64'(exp_q.size()), 64'd0);

    // Randomized stream of 200 words with random valid/ready.
    p0 = n_push;
    q0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      if (n_push - p0 < 200)
        drive_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
      else if (exp_q.size() != 0)
        drive_cycle(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
      else
        break;
    end
    drain(5);
    chk("rand_pushed", 64'(n_push - p0), 64'd200);
    chk("rand_popped", 64'(n_pop - q0), 64'd200);

    // Fill to 20, pop once so a read is in flight, then FLUSH.
    p0 = n_push;
    for (int i = 0; i < 50; i++) begin
      if (n_push - p0 >= 20) break;
      drive_cycle(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b0);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    chk("flush_rd_valid", 64'(RD_VALID), 64'd0);
    q0 = n_pop;
    drive_cycle(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0);
    drain(8);
    chk("flush_next_word", 64'(last_pop_data), 64'hA5A5_A5A5);
    chk("flush_pop_count", 64'(n_pop - q0), 64'd1);

    // Reset mid-stream with 10 words stored.
    p0 = n_push;
    for (int i = 0; i < 30; i++) begin
      if (n_push - p0 >= 10) break;
      drive_cycle(1'b1, 32'h3000_0000 + 32'(i), 1'b0, 1'b0);
    end
    chk("pre_rst_rd_valid", 64'(RD_VALID), 64'd1);
    WR_VALID = 1'b1;
    WR_DATA  = 32'hDEAD_BEEF;
    RD_READY = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_rd_valid", 64'(RD_VALID), 64'd0);
    chk("mid_rst_rd_data", 64'(RD_DATA), 64'd0);
    chk("mid_rst_wr_ready", 64'(WR_READY), 64'd0);
    chk("mid_rst_sram_en", 64'({SRAM_ENA, SRAM_WEA, SRAM_ENB}), 64'd0);
    chk("mid_rst_sram_dina", 64'(SRAM_DINA), 64'd0);
    chk("mid_rst_sram_addr", 64'({SRAM_ADDRA, SRAM_ADDRB}), 64'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    WR_VALID = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
    #1;
    chk("post_rst_wr_ready", 64'(WR_READY), 64'd1);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      chk("post_rst_empty", 64'(RD_VALID), 64'd0);
    end
    q0 = n_pop;
    drive_cycle(1'b1, 32'h0BAD_F00D, 1'b1, 1'b0);
    drain(8);
    chk("post_rst_word", 64'(last_pop_data), 64'h0BAD_F00D);
    chk("post_rst_pop_count", 64'(n_pop - q0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

Single-clock FIFO controller that turns the dual-port `sram` (write port A, registered read port B) into a valid/ready stream buffer. It sits between an APB peripheral's producer logic and its consumer. It drives `sram` port A to push words and port B to prefetch words. A 2-entry output buffer hides the SRAM's 1-cycle read latency and sustains 1 word/cycle. Both `sram` clocks (`CLKA`, `CLKB`) are tied to this block's `CLK`.

## Interface
- `DWIDTH`, 32, data word width; must match `sram`.
- `AWIDTH`, 5, SRAM address width; SRAM depth `2^AWIDTH`.
- `CLK` in 1: single clock, rising edge; also drives `sram` `CLKA`/`CLKB`.
- `RST` in 1: reset, asynchronous, active-high.
- `FLUSH` in 1: synchronous clear of all contents.
- `WR_VALID` in 1: producer offers `WR_DATA`.
- `WR_READY` out 1: SRAM not full.
- `WR_DATA` in DWIDTH: push data.
- `RD_VALID` out 1: `RD_DATA` holds the head word.
- `RD_READY` in 1: consumer accepts the head word.
- `RD_DATA` out DWIDTH: head word, registered.
- `SRAM_ENA`, `SRAM_WEA` out 1: port A enable and write enable.
- `SRAM_ADDRA` out AWIDTH: port A address.
- `SRAM_DINA` out DWIDTH: port A data.
- `SRAM_ENB` out 1: port B enable.
- `SRAM_ADDRB` out AWIDTH: port B address.
- `SRAM_DOUTB` in DWIDTH: registered read data from `sram`.

## Operation
- **Pointers.**
  - `wptr` and `rptr` are AWIDTH+1 bits and wrap modulo `2^(AWIDTH+1)`.
  - `mem_cnt = wptr - rptr`; full when `mem_cnt == 2^AWIDTH`, empty when 0.
- **Write.**
  - `push = WR_VALID & WR_READY`, with `WR_READY = !mem_full`.
  - Port A outputs are combinational: `SRAM_ENA = SRAM_WEA = push`, `SRAM_ADDRA = wptr[AWIDTH-1:0]`, `SRAM_DINA = WR_DATA`.
  - `wptr` increments on `push`.
- **Prefetch.**
  - `fetch = !mem_empty & (out_cnt + inflight - pop) < 2`, where `pop = RD_VALID & RD_READY`.
  - `SRAM_ENB = fetch`, `SRAM_ADDRB = rptr[AWIDTH-1:0]`.
  - `rptr` increments on `fetch`; the `inflight` flag is set for the next cycle.
- **Capture.**
  - When `inflight` is set, `SRAM_DOUTB` is written into the output buffer: slot 0 if it is empty or being popped, otherwise slot 1.
  - On `pop`, slot 1 shifts into slot 0.
  - `RD_VALID = (out_cnt != 0)`; `RD_DATA` is slot 0.
- **Ordering.** Words are delivered in strict push order. There is no loss and no duplication.
- **Same-cycle events.**
  - Push and fetch in one cycle never address the same location: fetch uses the registered `mem_cnt`, which excludes the current push.
  - A word written at edge N is fetchable from the cycle after edge N.
  - Simultaneous push and pop are always allowed when not full.
- **Capacity.** Total storage is `2^AWIDTH + 2` words. `WR_READY` depends only on SRAM fullness.
- **FLUSH.**
  - Clears both pointers, `out_cnt` and `inflight`, and drops any in-flight read.
  - `push` is suppressed in the FLUSH cycle (`WR_READY` forced 0).
  - `RD_VALID` is 0 from the next cycle.
- **Reset (`RST` high).**
  - Pointers, `out_cnt` and `inflight` are 0.
  - `RD_DATA` is 0 and `RD_VALID` is 0.
  - `WR_READY` is 0 while `RST` is high and 1 after release.
  - All `SRAM_*` outputs are 0.
  - Reset mid-operation discards all contents immediately. SRAM contents are not cleared (not needed).

## Timing
- Empty FIFO, push at edge k: fetch in cycle k+1, `DOUTB` valid after edge k+1, captured at edge k+2. `RD_VALID` is high in the cycle after edge k+2, i.e. 3-cycle first-word latency.
- Steady state with `RD_READY` held high: 1 word/cycle, no bubbles.
- `RD_VALID`/`RD_DATA` are stable while `RD_READY` is low; they change only on `pop`, capture, FLUSH or RST.
- `WR_READY` is combinational from registered state and FLUSH; it has no path from `WR_VALID`.

## Configuration
- `SRAM_FIFO_STATUS_EN` defined:
  - Adds output `LEVEL` [AWIDTH+1:0] = `mem_cnt + out_cnt + inflight`, registered, 0 at reset and after FLUSH.
  - Adds sticky output `OVERFLOW`, set when `WR_VALID & !WR_READY` (FLUSH cycle excluded).
  - Adds input `CLR_ERR`, which clears `OVERFLOW` synchronously. If set and clear coincide, set wins.
- Not defined: `LEVEL`, `OVERFLOW` and `CLR_ERR` ports and their logic are absent. Behaviour is otherwise identical.

## Test plan
- After reset, push 0x00000001..0x00000003 on consecutive cycles with `RD_READY`=1: `RD_VALID` first rises 3 cycles after the first push, then three consecutive beats 1, 2, 3.
- With `RD_READY`=0, push until `WR_READY` drops: exactly 34 words accepted (AWIDTH=5). Then pop all: values in order and 0 extra beats.
- Stream 200 words with `RD_READY` = pseudo-random 50% and `WR_VALID` = random: the output sequence equals the input sequence, and `RD_DATA` is stable while stalled.
- Fill to 20 words, assert FLUSH for 1 cycle during an active fetch: `RD_VALID`=0 next cycle. A following push of 0xA5A5A5A5 is the next word read.
- Assert `RST` mid-stream with 10 words stored: all outputs go to reset values asynchronously, and after release the FIFO is empty.
- With `SRAM_FIFO_STATUS_EN` defined:
  - Fill to full and drive `WR_VALID`=1 one more cycle: `OVERFLOW`=1 and `LEVEL`=34.
  - `CLR_ERR` pulse: `OVERFLOW`=0.
